// File: rtl/bram32_pkg.sv
// ---------------------------------------------------------------------------
// bram32_pkg
// Shared constants and loader state encoding for the 32-entry, 13-bit
// multi-read-port sample buffer. Used by the write-side loader, the buffer
// itself and the read-side consumers so that geometry stays in one place.
//   DEPTH  : words per frame (equals buffer depth, power of two)
//   ADDR_W : log2(DEPTH)
//   DATA_W : sample width
// ---------------------------------------------------------------------------
package bram32_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } loader_state_e;

endpackage : bram32_pkg

// File: rtl/bram32_loader.sv
// ---------------------------------------------------------------------------
// bram32_loader
// Write-side loader for the bram32 sample buffer. Accepts one frame of DEPTH
// samples over a valid/ready stream and writes them to buffer addresses
// 0..DEPTH-1, then holds the frame and raises frame_full until the consumer
// pulses frame_release. The loader is the only driver of the buffer's write
// port.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   frame_start   in   pulse, arms a new fill (honoured only in IDLE)
//   s_valid       in   input sample valid
//   s_data        in   input sample [DATA_W]
//   s_ready       out  sample accepted this cycle (FILL state)
//   s_last        in   final-sample marker        (LOADER_LAST_CHECK_EN only)
//   write_en      out  buffer write strobe
//   write_addr    out  buffer write address [ADDR_W]
//   write_data    out  buffer write data [DATA_W]
//   fill_level    out  samples accepted this frame, 0..DEPTH [ADDR_W+1]
//   frame_full    out  buffer holds a complete frame
//   frame_release in   pulse from consumer, frees the buffer
//   len_err       out  sticky length error        (LOADER_LAST_CHECK_EN only)
//
// Configuration macro: LOADER_LAST_CHECK_EN adds s_last/len_err and the
// frame-length check. Without it those ports and the logic are absent.
// ---------------------------------------------------------------------------
module bram32_loader
    import bram32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
`ifdef LOADER_LAST_CHECK_EN
    input  logic              s_last,
    output logic              len_err,
`endif
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [ADDR_W:0]   fill_level,
    output logic              frame_full,
    input  logic              frame_release
);

    loader_state_e     state_q;
    logic              write_en_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0] write_data_q;
    logic [ADDR_W:0]   fill_level_q;
    logic [ADDR_W:0]   fill_level_d;
    logic              frame_full_q;
    logic              last_slot;
`ifdef LOADER_LAST_CHECK_EN
    logic              len_err_q;
`endif

    assign fill_level_d = fill_level_q + (ADDR_W+1)'(1);
    assign last_slot    = (fill_level_q == (ADDR_W+1)'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            fill_level_q <= '0;
            frame_full_q <= 1'b0;
`ifdef LOADER_LAST_CHECK_EN
            len_err_q    <= 1'b0;
`endif
        end else begin
            // Strobe is a single-cycle pulse per handshake; address/data hold.
            write_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    frame_full_q <= 1'b0;
                    if (frame_start) begin
                        state_q      <= FILL;
                        fill_level_q <= '0;
`ifdef LOADER_LAST_CHECK_EN
                        len_err_q    <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    frame_full_q <= 1'b0;
                    // s_ready is 1 throughout FILL, so s_valid alone is the handshake.
                    if (s_valid) begin
                        write_en_q   <= 1'b1;
                        write_addr_q <= fill_level_q[ADDR_W-1:0];
                        write_data_q <= s_data;
                        fill_level_q <= fill_level_d;
                        if (last_slot) begin
                            state_q <= FULL;
                        end
`ifdef LOADER_LAST_CHECK_EN
                        if (s_last != last_slot) begin
                            len_err_q <= 1'b1;
                        end
`endif
                    end
                end
                FULL: begin
                    // frame_full lags entry into FULL by one cycle so it only
                    // rises once the final write has landed in the buffer.
                    if (frame_release) begin
                        state_q      <= IDLE;
                        frame_full_q <= 1'b0;
                    end else begin
                        frame_full_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    frame_full_q <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from the state register only: no input-to-ready path.
    assign s_ready    = (state_q == FILL);
    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign fill_level = fill_level_q;
    assign frame_full = frame_full_q;
`ifdef LOADER_LAST_CHECK_EN
    assign len_err    = len_err_q;
`endif

endmodule : bram32_loader

// File: tb/tb_bram32_loader.sv
// ---------------------------------------------------------------------------
// tb_bram32_loader
// Randomised bench for bram32_loader. The stimulus process tracks the frame
// as a sample count and pushes every expected buffer write (address, data)
// into a queue; a separate monitor pops and compares on each write strobe.
// ---------------------------------------------------------------------------
module tb_bram32_loader;
    import bram32_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic              s_last = 1'b0;
    logic              len_err;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W:0]   fill_level;
    logic              frame_full;
    logic              frame_release = 1'b0;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    bram32_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
`ifdef LOADER_LAST_CHECK_EN
        .s_last       (s_last),
        .len_err      (len_err),
`endif
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .fill_level   (fill_level),
        .frame_full   (frame_full),
        .frame_release(frame_release)
    );

`ifndef LOADER_LAST_CHECK_EN
    assign len_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && write_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {write_addr, write_data}, 32'hDEAD);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(write_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                chk("write_data", 32'(write_data), 32'(e[DATA_W-1:0]));
                $display("write addr=%0d data=0x%04h", write_addr, write_data);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_ready"},    32'(s_ready),    32'd0);
        chk({tag, "_write_en"},   32'(write_en),   32'd0);
        chk({tag, "_write_addr"}, 32'(write_addr), 32'd0);
        chk({tag, "_write_data"}, 32'(write_data), 32'd0);
        chk({tag, "_fill_level"}, 32'(fill_level), 32'd0);
        chk({tag, "_frame_full"}, 32'(frame_full), 32'd0);
        chk({tag, "_len_err"},    32'(len_err),    32'd0);
    endtask

    // One frame: gap_pct = % of idle cycles, seq = data equals index,
    // glitch_at = sample index where frame_start/frame_release are pulsed,
    // rst_at = sample index where reset is asserted (frame abandoned),
    // last_at = sample index carrying s_last.
    task automatic run_frame(input int gap_pct, input bit seq, input int glitch_at,
                             input int rst_at, input int last_at);
        int  cnt = 0;
        int  cycles = 0;
        bit  glitched = 1'b0;
        bit  err_exp = 1'b0;
        bit  v;
        logic [DATA_W-1:0] d;

        @(negedge clk);
        frame_start = 1'b1;
        s_valid     = 1'b1;            // must not be taken while still in IDLE
        s_data      = DATA_W'(13'h1ABC);
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        s_valid     = 1'b0;
        chk("start_fill_level", 32'(fill_level), 32'd0);
        chk("start_len_err",    32'(len_err),    32'd0);

        while (cnt < DEPTH) begin
            if (cycles++ > 2000) begin
                chk("fill_timeout", 32'(cnt), 32'(DEPTH));
                return;
            end
            chk("fill_s_ready",    32'(s_ready),    32'd1);
            chk("fill_level",      32'(fill_level), 32'(cnt));
            chk("fill_frame_full", 32'(frame_full), 32'd0);
`ifdef LOADER_LAST_CHECK_EN
            chk("fill_len_err",    32'(len_err),    32'(err_exp));
`endif
            if (cnt == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_values("async_rst");
                exp_q.delete();
                @(negedge clk);
                check_reset_values("held_rst");
                rst_n = 1'b1;
                $display("reset asserted at sample %0d", cnt);
                return;
            end
            v = ($urandom_range(0, 99) >= gap_pct);
            d = seq ? DATA_W'(cnt) : DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            s_valid = v;
            s_data  = d;
            s_last  = v && (cnt == last_at);
            if (cnt == glitch_at && !glitched) begin
                frame_start   = 1'b1;
                frame_release = 1'b1;
                glitched      = 1'b1;
            end
            @(posedge clk);
            if (v) begin
                exp_q.push_back({ADDR_W'(cnt), d});
                if ((cnt == last_at) != (cnt == DEPTH - 1)) err_exp = 1'b1;
                cnt++;
            end
            @(negedge clk);
            s_valid       = 1'b0;
            s_last        = 1'b0;
            frame_start   = 1'b0;
            frame_release = 1'b0;
            #0;
            if (cnt < DEPTH) begin
                // loop top re-checks at this same negedge
            end
        end

        // Final write strobe is up now; frame_full must still be low.
        chk("end_s_ready",    32'(s_ready),    32'd0);
        chk("end_frame_full", 32'(frame_full), 32'd0);
        chk("end_fill_level", 32'(fill_level), 32'(DEPTH));
        @(negedge clk);
        chk("full_frame_full", 32'(frame_full), 32'd1);
`ifdef LOADER_LAST_CHECK_EN
        chk("end_len_err", 32'(len_err), 32'(err_exp));
`endif
        $display("frame done: %0d samples in %0d cycles", cnt, cycles);
    endtask

    // Hold FULL with hostile inputs, then release.
    task automatic hold_and_release(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid     = 1'b1;
            s_data      = DATA_W'(13'h1FFF);
            frame_start = (i == 3);
            @(posedge clk);
            @(negedge clk);
            frame_start = 1'b0;
            chk("hold_s_ready",    32'(s_ready),    32'd0);
            chk("hold_frame_full", 32'(frame_full), 32'd1);
            chk("hold_fill_level", 32'(fill_level), 32'(DEPTH));
        end
        s_valid       = 1'b0;
        frame_release = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_release = 1'b0;
        chk("rel_frame_full", 32'(frame_full), 32'd0);
        chk("rel_s_ready",    32'(s_ready),    32'd0);
        chk("rel_fill_level", 32'(fill_level), 32'(DEPTH));
        $display("frame released");
    endtask

    initial begin
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back, data 0..31.
        run_frame(0, 1'b1, -1, -1, DEPTH - 1);
        hold_and_release(10);

        // Random gaps with frame_start/frame_release glitch at sample 10.
        run_frame(50, 1'b0, 10, -1, DEPTH - 1);
        hold_and_release(2);

        // Reset at sample 17, then a fresh frame from address 0.
        run_frame(30, 1'b0, -1, 17, DEPTH - 1);
        run_frame(50, 1'b0, -1, -1, DEPTH - 1);
        hold_and_release(1);

`ifdef LOADER_LAST_CHECK_EN
        // Early s_last flags len_err; following frame clears it.
        run_frame(20, 1'b0, -1, -1, 20);
        hold_and_release(1);
        run_frame(20, 1'b0, -1, -1, DEPTH - 1);
        hold_and_release(1);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_bram32_loader

// File: doc/bram32_loader.md
# bram32_loader

Write-side loader for the 32-entry, 13-bit multi-read-port sample buffer in the MIMO-OFDM datapath. Accepts one frame of `DEPTH` samples over a valid/ready stream, drives the buffer's single write port at sequential addresses 0..DEPTH-1, then holds the frame stable and raises `frame_full` until the read-side consumer releases it. The loader owns the buffer's `write_en`/`write_addr`/`write_data` inputs exclusively.

## Interface
- `DEPTH`, 32: words per frame; must equal buffer depth, power of two.
- `ADDR_W`, 5: address width, log2(DEPTH).
- `DATA_W`, 13: sample width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `frame_start`  in  1  one-cycle pulse; arms a new fill (honoured only in IDLE).
- `s_valid`  in  1  input sample valid.
- `s_data`  in  DATA_W  input sample.
- `s_ready`  out  1  loader accepts a sample this cycle.
- `s_last`  in  1  marks final sample (only with LOADER_LAST_CHECK_EN).
- `write_en`  out  1  buffer write strobe.
- `write_addr`  out  ADDR_W  buffer write address.
- `write_data`  out  DATA_W  buffer write data.
- `fill_level`  out  ADDR_W+1  samples accepted in current frame, 0..DEPTH.
- `frame_full`  out  1  buffer holds a complete frame; readers may read.
- `frame_release`  in  1  one-cycle pulse from consumer; frees the buffer.
- `len_err`  out  1  sticky frame-length error (only with LOADER_LAST_CHECK_EN).

## Operation
- States: IDLE, FILL, FULL. Reset state IDLE.
- IDLE: `s_ready`=0. `frame_start` -> FILL, `fill_level` cleared to 0.
- FILL: `s_ready`=1. Handshake = `s_valid && s_ready`. Each handshake registers `write_en`=1, `write_addr`=`fill_level[ADDR_W-1:0]`, `write_data`=`s_data`; `fill_level` increments. Cycles without handshake register `write_en`=0; `write_addr`/`write_data` hold.
- Handshake with `fill_level`==DEPTH-1 -> FULL; `fill_level` becomes DEPTH. No wrap: address DEPTH-1 is the last written.
- FULL: `s_ready`=0, `frame_full`=1, no writes. `frame_release` -> IDLE, `frame_full` drops; `fill_level` holds until next `frame_start`.
- `frame_start` in FILL or FULL: ignored. `frame_release` in IDLE or FILL: ignored.
- `frame_start` and `s_valid` in same IDLE cycle: sample not accepted (`s_ready`=0).
- Reset mid-fill: all state cleared to IDLE immediately; partially written buffer contents are stale and not flagged.

## Timing
- Reset values: `s_ready`=0, `write_en`=0, `write_addr`=0, `write_data`=0, `fill_level`=0, `frame_full`=0, `len_err`=0.
- `s_ready` decoded from state register only (no combinational path from inputs).
- Write latency: handshake at edge N -> `write_en` high during cycle N..N+1 -> buffer captures at edge N+1.
- `frame_full` rises after edge N+1 when N is the last handshake, so the first read issued while `frame_full`=1 returns frame data.
- Throughput: one sample per cycle; full frame in DEPTH cycles of continuous `s_valid`.
- `frame_release` sampled at edge M -> `frame_full`=0 after M; next `frame_start` accepted at edge M+1 earliest.

## Configuration
- `LOADER_LAST_CHECK_EN` defined: `s_last` and `len_err` ports present. `len_err` sets on a handshake with `s_last`=1 and `fill_level`!=DEPTH-1, or `s_last`=0 and `fill_level`==DEPTH-1. Fill continues to DEPTH regardless. `len_err` cleared only by accepted `frame_start` or reset.
- Not defined: `s_last` and `len_err` ports absent; no length checking logic.

## Structure
- Shared package `bram32_pkg`: `DEPTH`, `ADDR_W`, `DATA_W` constants and the loader state enum (IDLE/FILL/FULL), reused by the buffer and read-side consumers.
- Single module; no sub-module warranted.

## Test plan
- Reset then `frame_start`, 32 back-to-back samples 0x0000..0x001F -> writes addr 0..31 with matching data, `frame_full`=1 one cycle after last write, `fill_level`=32.
- Random `s_valid` gaps (~50%) -> writes only on handshakes, addresses contiguous, no missing/duplicate data.
- In FULL, `s_valid`=1 with 0x1FFF for 10 cycles -> `s_ready`=0, no `write_en`; buffer unchanged; `frame_release` -> IDLE next cycle.
- `frame_start` pulsed at sample 10 mid-fill and `frame_release` in FILL -> both ignored, fill completes at 32.
- `rst_n` low at sample 17 -> all outputs to reset values asynchronously; new `frame_start` restarts at address 0.
- With `LOADER_LAST_CHECK_EN`: `s_last` on sample 20 -> `len_err`=1, fill still reaches 32; next `frame_start` clears it.
